// File: rtl/corevx_tlb_ctrl.sv
// corevx_tlb_ctrl
// Sequencer and arbiter for an array of WAYS corevx_tlb_way instances. It takes
// one command at a time from the MMU / page-table walker, drives the ways'
// command strobes, merges the per-way resolve results into a single response,
// and keeps a round-robin victim pointer for refills.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where both
// valid and ready are high. A requester holds valid and its payload stable until
// that edge. cmd_ready is high only while the controller is idle. resp_valid
// stays high with resp_* frozen until the consumer takes it with resp_ready.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   cmd_*                command channel (op 01 resolve, 10 write, 11 invalidate,
//                        00 accepted and ignored)
//   resp_*               resolve result channel
//   way_resolve/write/invalidate  single-cycle command strobes to the ways
//   way_enable/vaddr/accesstag_w/phys_w  command payload registered on accept
//   way_miss/done/accesstag_r/phys_r     per-way results, way i in slice i
//   fsm_state            current controller state, for observation only
module corevx_tlb_ctrl #(
   parameter int WAYS   = 4,
   parameter int WAYS_W = $clog2(WAYS)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [19:0]        cmd_vaddr,
   input  logic               cmd_enable,
   input  logic [7:0]         cmd_accesstag,
   input  logic [21:0]        cmd_phys,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic               resp_miss,
   output logic               resp_multihit,
   output logic [7:0]         resp_accesstag,
   output logic [21:0]        resp_phys,
   output logic               way_resolve,
   output logic [WAYS-1:0]    way_write,
   output logic               way_invalidate,
   output logic               way_enable,
   output logic [19:0]        way_vaddr,
   output logic [7:0]         way_accesstag_w,
   output logic [21:0]        way_phys_w,
   input  logic [WAYS-1:0]    way_miss,
   input  logic [WAYS-1:0]    way_done,
   input  logic [8*WAYS-1:0]  way_accesstag_r,
   input  logic [22*WAYS-1:0] way_phys_r,
   output logic [2:0]         fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_RESP  = 3'd3,
      S_WR    = 3'd4,
      S_INV   = 3'd5
   } state_t;

   state_t            state, state_nx;
   logic [WAYS_W-1:0] victim;

   logic [WAYS-1:0]   hit;
   logic [WAYS_W:0]   hit_cnt;
   logic              sel_found;
   logic [7:0]        sel_tag;
   logic [21:0]       sel_phys;
   logic              all_done;
   logic              accept;

   assign all_done  = &way_done;
   assign accept    = (state == S_IDLE) && cmd_valid;
   assign fsm_state = state;

   // Merge the way results: lowest-index hit wins, way 0 when nothing hits.
   always_comb begin
      hit       = ~way_miss;
      hit_cnt   = '0;
      sel_found = 1'b0;
      sel_tag   = way_accesstag_r[7:0];
      sel_phys  = way_phys_r[21:0];
      for (int i = 0; i < WAYS; i++) begin
         if (hit[i]) begin
            hit_cnt = hit_cnt + {{WAYS_W{1'b0}}, 1'b1};
            if (!sel_found) begin
               sel_found = 1'b1;
               sel_tag   = way_accesstag_r[i*8 +: 8];
               sel_phys  = way_phys_r[i*22 +: 22];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         victim          <= '0;
         resp_miss       <= 1'b0;
         resp_multihit   <= 1'b0;
         resp_accesstag  <= '0;
         resp_phys       <= '0;
         way_enable      <= 1'b0;
         way_vaddr       <= '0;
         way_accesstag_w <= '0;
         way_phys_w      <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            way_enable      <= cmd_enable;
            way_vaddr       <= cmd_vaddr;
            way_accesstag_w <= cmd_accesstag;
            way_phys_w      <= cmd_phys;
         end
         if (state == S_WAIT && all_done) begin
            resp_miss      <= ~|hit;
            // With translation disabled every way reports a hit, so a
            // multi-hit there is expected and not an error.
            resp_multihit  <= (hit_cnt > (WAYS_W+1)'(1)) && way_enable;
            resp_accesstag <= sel_tag;
            resp_phys      <= sel_phys;
         end
         if (state == S_WR) begin
            victim <= victim + {{(WAYS_W-1){1'b0}}, 1'b1};
         end else if (state == S_INV) begin
            victim <= '0;
         end
      end
   end

   always_comb begin
      state_nx       = state;
      cmd_ready      = 1'b0;
      resp_valid     = 1'b0;
      way_resolve    = 1'b0;
      way_invalidate = 1'b0;
      way_write      = '0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (cmd_op)
                  2'b01:   state_nx = S_ISSUE;
                  2'b10:   state_nx = S_WR;
                  2'b11:   state_nx = S_INV;
                  default: state_nx = S_IDLE;
               endcase
            end
         end
         S_ISSUE: begin
            way_resolve = 1'b1;
            state_nx    = S_WAIT;
         end
         S_WAIT: begin
            if (all_done) state_nx = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nx = S_IDLE;
         end
         S_WR: begin
            way_write = {{(WAYS-1){1'b0}}, 1'b1} << victim;
            state_nx  = S_IDLE;
         end
         S_INV: begin
            way_invalidate = 1'b1;
            state_nx       = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_corevx_tlb_ctrl.sv
// Testbench for corevx_tlb_ctrl: directed and randomised commands, with the
// ways emulated by bench-driven miss/done/data vectors and expected results
// computed from the command rules.
module tb_corevx_tlb_ctrl;
   localparam int WAYS   = 4;
   localparam int WAYS_W = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [19:0]        cmd_vaddr;
   logic               cmd_enable;
   logic [7:0]         cmd_accesstag;
   logic [21:0]        cmd_phys;
   logic               resp_valid;
   logic               resp_ready;
   logic               resp_miss;
   logic               resp_multihit;
   logic [7:0]         resp_accesstag;
   logic [21:0]        resp_phys;
   logic               way_resolve;
   logic [WAYS-1:0]    way_write;
   logic               way_invalidate;
   logic               way_enable;
   logic [19:0]        way_vaddr;
   logic [7:0]         way_accesstag_w;
   logic [21:0]        way_phys_w;
   logic [WAYS-1:0]    way_miss;
   logic [WAYS-1:0]    way_done;
   logic [8*WAYS-1:0]  way_accesstag_r;
   logic [22*WAYS-1:0] way_phys_r;
   logic [2:0]         fsm_state;

   logic [7:0]         tag_arr  [WAYS];
   logic [21:0]        phys_arr [WAYS];

   int n_checks = 0;
   int n_fail   = 0;
   int exp_victim = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < WAYS; i++) begin
         way_accesstag_r[i*8 +: 8] = tag_arr[i];
         way_phys_r[i*22 +: 22]    = phys_arr[i];
      end
   end

   corevx_tlb_ctrl #(.WAYS(WAYS), .WAYS_W(WAYS_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_vaddr(cmd_vaddr), .cmd_enable(cmd_enable),
      .cmd_accesstag(cmd_accesstag), .cmd_phys(cmd_phys),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_miss(resp_miss), .resp_multihit(resp_multihit),
      .resp_accesstag(resp_accesstag), .resp_phys(resp_phys),
      .way_resolve(way_resolve), .way_write(way_write),
      .way_invalidate(way_invalidate), .way_enable(way_enable),
      .way_vaddr(way_vaddr), .way_accesstag_w(way_accesstag_w),
      .way_phys_w(way_phys_w), .way_miss(way_miss), .way_done(way_done),
      .way_accesstag_r(way_accesstag_r), .way_phys_r(way_phys_r),
      .fsm_state(fsm_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_no_strobes(input string tag);
      chk({tag, "_strobes"}, {way_resolve, way_invalidate, 28'd0, way_write}, 32'd0);
   endtask

   task automatic randomize_ways();
      for (int i = 0; i < WAYS; i++) begin
         tag_arr[i]  = 8'($urandom);
         phys_arr[i] = 22'($urandom);
      end
   endtask

   task automatic drive_cmd(input logic [1:0] op, input logic [19:0] va, input logic en,
                            input logic [7:0] tg, input logic [21:0] ph);
      cmd_valid     = 1'b1;
      cmd_op        = op;
      cmd_vaddr     = va;
      cmd_enable    = en;
      cmd_accesstag = tg;
      cmd_phys      = ph;
   endtask

   task automatic do_write(input logic [19:0] va, input logic [7:0] tg, input logic [21:0] ph);
      @(negedge clk);
      chk("wr_ready", cmd_ready, 1);
      drive_cmd(2'b10, va, 1'b0, tg, ph);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("wr_strobe", way_write, 32'(1 << exp_victim));
      chk("wr_other", {way_resolve, way_invalidate}, 0);
      chk("wr_vaddr", way_vaddr, va);
      chk("wr_tag", way_accesstag_w, tg);
      chk("wr_phys", way_phys_w, ph);
      exp_victim = (exp_victim + 1) % WAYS;
      @(negedge clk);
      chk_no_strobes("wr_after");
      chk("wr_ready_back", cmd_ready, 1);
   endtask

   task automatic do_inv();
      @(negedge clk);
      chk("inv_ready", cmd_ready, 1);
      drive_cmd(2'b11, 20'($urandom), 1'b1, 8'($urandom), 22'($urandom));
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("inv_strobe", way_invalidate, 1);
      chk("inv_other", {way_resolve, 28'd0, way_write}, 0);
      chk("inv_busy", cmd_ready, 0);
      exp_victim = 0;
      @(negedge clk);
      chk_no_strobes("inv_after");
      chk("inv_ready_back", cmd_ready, 1);
   endtask

   // miss: per-way miss vector the emulated ways will report.
   // delay: cycles in WAIT with an incomplete done vector.
   // hold: cycles the consumer keeps resp_ready low.
   task automatic do_resolve(input logic [19:0] va, input logic en, input logic [WAYS-1:0] miss,
                             input int delay, input int hold);
      logic [WAYS-1:0] hits;
      int              sel;
      logic            e_miss, e_multi;
      logic [7:0]      e_tag;
      logic [21:0]     e_phys;
      hits = ~miss;
      sel  = 0;
      for (int i = WAYS - 1; i >= 0; i--) if (hits[i]) sel = i;
      e_miss  = (hits == '0);
      e_multi = en && ($countones(hits) > 1);
      e_tag   = tag_arr[sel];
      e_phys  = phys_arr[sel];

      @(negedge clk);
      chk("rs_ready", cmd_ready, 1);
      drive_cmd(2'b01, va, en, 8'($urandom), 22'($urandom));
      way_miss = miss;
      way_done = '0;
      @(negedge clk);                       // T+1 ISSUE
      cmd_valid = 1'b0;
      chk("rs_resolve", way_resolve, 1);
      chk("rs_busy", cmd_ready, 0);
      chk("rs_vaddr", way_vaddr, va);
      chk("rs_enable", way_enable, en);
      @(negedge clk);                       // T+2 WAIT
      chk_no_strobes("rs_wait");
      chk("rs_wait_valid", resp_valid, 0);
      for (int d = 0; d < delay; d++) begin
         way_done = WAYS'($urandom_range(0, (1 << WAYS) - 2));
         @(negedge clk);
         chk("rs_stall_valid", resp_valid, 0);
         chk_no_strobes("rs_stall");
      end
      way_done = '1;
      @(negedge clk);                       // RESP
      way_done = '0;
      for (int h = 0; h <= hold; h++) begin
         chk("rs_valid", resp_valid, 1);
         chk("rs_miss", resp_miss, e_miss);
         chk("rs_multihit", resp_multihit, e_multi);
         chk("rs_tag", resp_accesstag, e_tag);
         chk("rs_phys", resp_phys, e_phys);
         chk("rs_resp_busy", cmd_ready, 0);
         chk_no_strobes("rs_resp");
         if (h < hold) begin
            // Disturb the ways and offer a command; neither may leak through.
            randomize_ways();
            way_miss = WAYS'($urandom);
            drive_cmd(2'b10, 20'($urandom), 1'b1, 8'($urandom), 22'($urandom));
            @(negedge clk);
         end
      end
      cmd_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("rs_done_valid", resp_valid, 0);
      chk("rs_done_ready", cmd_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_op     = 2'b00;
      cmd_vaddr  = '0;
      cmd_enable = 1'b0;
      cmd_accesstag = '0;
      cmd_phys   = '0;
      resp_ready = 1'b0;
      way_miss   = '1;
      way_done   = '0;
      randomize_ways();
      repeat (3) @(negedge clk);

      // Reset state.
      chk("rst_ready", cmd_ready, 1);
      chk("rst_valid", resp_valid, 0);
      chk("rst_resp", {resp_miss, resp_multihit, resp_phys}, 0);
      chk("rst_rtag", resp_accesstag, 0);
      chk_no_strobes("rst");
      chk("rst_wregs", {way_enable, way_phys_w, way_accesstag_w}, 0);
      chk("rst_wvaddr", way_vaddr, 0);
      rst_n = 1'b1;

      // Invalidate timing, then five refills walking the victim pointer.
      do_inv();
      for (int i = 0; i < 5; i++) do_write(20'h00012, 8'h01, 22'h3ABCD);

      // Op 00 is accepted and does nothing.
      @(negedge clk);
      drive_cmd(2'b00, 20'h1, 1'b1, 8'h1, 22'h1);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("nop_ready", cmd_ready, 1);
      chk_no_strobes("nop");

      // Way 1 hit.
      randomize_ways();
      tag_arr[1] = 8'h01; phys_arr[1] = 22'h3ABCD;
      do_resolve(20'h00012, 1'b1, 4'b1101, 0, 0);
      // No hit, ways 1 and 3 hit, all hit.
      randomize_ways();
      do_resolve(20'h00034, 1'b1, 4'b1111, 0, 0);
      randomize_ways();
      do_resolve(20'h00056, 1'b1, 4'b0101, 1, 0);
      randomize_ways();
      do_resolve(20'h00078, 1'b1, 4'b0000, 0, 0);
      // Consumer back-pressure for five cycles.
      randomize_ways();
      do_resolve(20'hABCDE, 1'b1, 4'b1011, 0, 5);
      // Translation disabled: ways all report no miss, multi-hit suppressed.
      randomize_ways();
      do_resolve(20'h0F00F, 1'b0, 4'b0000, 2, 1);

      // Randomised command mix.
      for (int n = 0; n < 30; n++) begin
         int kind;
         kind = $urandom_range(0, 5);
         randomize_ways();
         if (kind < 3) begin
            logic en;
            en = 1'($urandom);
            do_resolve(20'($urandom), en, en ? WAYS'($urandom) : '0,
                       $urandom_range(0, 3), $urandom_range(0, 2));
         end else if (kind < 5) begin
            do_write(20'($urandom), 8'($urandom), 22'($urandom));
         end else begin
            do_inv();
         end
      end

      // Reset in the middle of a resolve.
      do_write(20'h1, 8'h1, 22'h1);
      @(negedge clk);
      drive_cmd(2'b01, 20'h55555, 1'b1, 8'h0, 22'h0);
      way_done = '0;
      way_miss = 4'b1110;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("mid_wait_valid", resp_valid, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", cmd_ready, 1);
      chk("mid_rst_valid", resp_valid, 0);
      chk_no_strobes("mid_rst");
      chk("mid_rst_vaddr", way_vaddr, 0);
      chk("mid_rst_resp", {resp_miss, resp_multihit, resp_phys}, 0);
      rst_n = 1'b1;
      exp_victim = 0;
      way_done = '1;
      @(negedge clk);
      chk("mid_rst_idle", resp_valid, 0);
      do_write(20'h2, 8'h3, 22'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
